iob_ram_tdp_arb: RTL and testbench

- Round-robin arbiter sharing one port of a synchronous dual-port RAM (1-cycle read latency) among N_REQ requesters.
- Sits between the requester cores and one RAM port. The RAM's other port stays free for a DMA or debug master.
- Valid/ready request channel per requester; fixed-latency read response routed back to the granted requester.

---
 rtl/iob_ram_tdp_arb_pkg.sv | 19 +
 rtl/iob_rr_prio_enc.sv | 33 +++
 rtl/iob_ram_tdp_arb.sv | 125 ++++++++++++
 tb/tb_iob_ram_tdp_arb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/iob_ram_tdp_arb_pkg.sv
// Shared types and helpers for the iob_ram_tdp_arb RAM-port arbiter.
// Optional lock feature macro: IOB_RAM_TDP_ARB_LOCK_EN.
package iob_ram_tdp_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_N_REQ = 4;

  // Index width for an N-way requester set; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_w(DEFAULT_N_REQ);

endpackage

// File: rtl/iob_rr_prio_enc.sv
// Round-robin priority encoder: first set request at or above ptr, wrapping modulo N.
// Combinational; outputs a one-hot grant, its binary index and an any-grant flag.
module iob_rr_prio_enc
  import iob_ram_tdp_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/iob_ram_tdp_arb.sv
// Round-robin arbiter sharing one synchronous RAM port among N_REQ requesters, 1-cycle read return.
// Optional grant locking is enabled by defining IOB_RAM_TDP_ARB_LOCK_EN.
module iob_ram_tdp_arb
  import iob_ram_tdp_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          req_lock,
`endif
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_din,
  input  logic [DATA_W-1:0]         ram_dout
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0]    prio_ptr;
  logic [IW-1:0]    rsp_sel;
  logic             rsp_pending;
  logic [N_REQ-1:0] enc_grant;
  logic [IW-1:0]    enc_idx;
  logic             enc_any;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    g_idx;
  logic             g_any;
  logic             g_acc;

  iob_rr_prio_enc #(
    .N  (N_REQ),
    .IW (IW)
  ) u_enc (
    .req   (req_valid),
    .ptr   (prio_ptr),
    .grant (enc_grant),
    .idx   (enc_idx),
    .any   (enc_any)
  );

`ifdef IOB_RAM_TDP_ARB_LOCK_EN
  arb_state_t    state;
  logic [IW-1:0] owner;
  logic          hold;

  assign hold = (state == ARB_LOCKED) && req_valid[owner] && req_lock[owner];

  always_comb begin
    if (hold) begin
      grant = N_REQ'(1) << owner;
      g_idx = owner;
      g_any = 1'b1;
    end else begin
      grant = enc_grant;
      g_idx = enc_idx;
      g_any = enc_any;
    end
  end

  // Owner keeps the port while valid & lock hold; any fresh locked grant re-enters LOCKED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= '0;
    end else if (!hold) begin
      if (g_acc && req_lock[g_idx]) begin
        state <= ARB_LOCKED;
        owner <= g_idx;
      end else begin
        state <= ARB_IDLE;
      end
    end
  end
`else
  assign grant = enc_grant;
  assign g_idx = enc_idx;
  assign g_any = enc_any;
`endif

  assign g_acc     = g_any && !rst;
  assign req_ready = rst ? '0 : grant;
  assign ram_en    = (|req_valid) && !rst;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (g_acc) begin
      ram_we   = req_we[g_idx];
      ram_addr = req_addr[g_idx*ADDR_W +: ADDR_W];
      ram_din  = req_wdata[g_idx*DATA_W +: DATA_W];
    end
  end

  // While locked g_idx stays at the owner, so the pointer naturally holds at owner+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr    <= '0;
      rsp_pending <= 1'b0;
      rsp_sel     <= '0;
    end else begin
      if (g_acc) begin
        prio_ptr <= (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
      end
      rsp_pending <= g_acc && !ram_we;
      rsp_sel     <= g_idx;
    end
  end

  assign rsp_valid = (rsp_pending && !rst) ? (N_REQ'(1) << rsp_sel) : '0;
  assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_iob_ram_tdp_arb.sv
// Directed table-driven bench for iob_ram_tdp_arb with a behavioural 1-cycle RAM.
// Lock sequence runs only when IOB_RAM_TDP_ARB_LOCK_EN is defined.
module tb_iob_ram_tdp_arb;

  localparam int N = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  typedef struct packed {
    logic               rst;
    logic [N-1:0]       valid;
    logic [N-1:0]       we;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0][DW-1:0] wdata;
    logic [N-1:0]       exp_ready;
    logic               exp_en;
    logic [N-1:0]       exp_rsp;
    logic [DW-1:0]      exp_rdata;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       req_we = '0;
  logic [N-1:0][AW-1:0] req_addr = '0;
  logic [N-1:0][DW-1:0] req_wdata = '0;
  logic [N-1:0]       req_lock = '0;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               ram_en;
  logic               ram_we;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_din;
  logic [DW-1:0]      ram_dout = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_ram_tdp_arb #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | {22'h0, a};
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_word(AW'(i));
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic row(input logic r, input logic [N-1:0] v, input logic [N-1:0] w,
                     input logic [N-1:0][AW-1:0] a, input logic [N-1:0][DW-1:0] d,
                     input logic [N-1:0] er, input logic een, input logic [N-1:0] ersp,
                     input logic [DW-1:0] erd);
    vec_t t;
    t.rst = r; t.valid = v; t.we = w; t.addr = a; t.wdata = d;
    t.exp_ready = er; t.exp_en = een; t.exp_rsp = ersp; t.exp_rdata = erd;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] lk, input logic [N-1:0] er, input int id);
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = v; req_we = '0; req_lock = lk; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    chk("lock_ready", id, 64'(req_ready), 64'(er));
  endtask

  initial begin
    logic [N-1:0][AW-1:0] za;
    logic [N-1:0][DW-1:0] zd;
    logic [N-1:0][AW-1:0] af;
    logic [N-1:0][AW-1:0] a5;
    logic [N-1:0][AW-1:0] a3ff;
    logic [N-1:0][DW-1:0] d1234;
    logic [N-1:0][DW-1:0] dbeef;
    logic [N-1:0][AW-1:0] a7;
    logic [N-1:0][AW-1:0] a21;
    za = '0; zd = '0;
    af    = {10'd19, 10'd18, 10'd17, 10'd16};
    a5    = {10'd0, 10'd0, 10'd0, 10'd5};
    a7    = {10'd7, 10'd0, 10'd0, 10'd0};
    a3ff  = {10'd0, 10'h3FF, 10'd0, 10'd0};
    a21   = {10'd0, 10'h22, 10'h21, 10'd0};
    d1234 = {32'h0, 32'h0000_1234, 32'h0, 32'h0};
    dbeef = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF};

    // reset with all valid, then preload 0x005 via a write from req0
    for (int i = 0; i < 3; i++) row(1, 4'b1111, 4'b0000, za, zd, 4'b0000, 0, 4'b0000, 0);
    row(0, 4'b1111, 4'b1111, a5, dbeef, 4'b0001, 1, 4'b0000, 0);
    row(0, 4'b0001, 4'b0000, a5, zd, 4'b0001, 1, 4'b0000, 0);
    row(0, 4'b0000, 4'b0000, za, zd, 4'b0000, 0, 4'b0001, 32'hDEAD_BEEF);
    row(0, 4'b1000, 4'b0000, a7, zd, 4'b1000, 1, 4'b0000, 0);
    // fairness: all four reading, pointer starts at 0
    row(0, 4'b1111, 4'b0000, af, zd, 4'b0001, 1, 4'b1000, init_word(10'd7));
    row(0, 4'b1111, 4'b0000, af, zd, 4'b0010, 1, 4'b0001, init_word(10'd16));
    row(0, 4'b1111, 4'b0000, af, zd, 4'b0100, 1, 4'b0010, init_word(10'd17));
    row(0, 4'b1111, 4'b0000, af, zd, 4'b1000, 1, 4'b0100, init_word(10'd18));
    row(0, 4'b1111, 4'b0000, af, zd, 4'b0001, 1, 4'b1000, init_word(10'd19));
    row(0, 4'b1111, 4'b0000, af, zd, 4'b0010, 1, 4'b0001, init_word(10'd16));
    row(0, 4'b1111, 4'b0000, af, zd, 4'b0100, 1, 4'b0010, init_word(10'd17));
    row(0, 4'b1111, 4'b0000, af, zd, 4'b1000, 1, 4'b0100, init_word(10'd18));
    // req2 write then read of 0x3FF
    row(0, 4'b0100, 4'b0100, a3ff, d1234, 4'b0100, 1, 4'b1000, init_word(10'd19));
    row(0, 4'b0100, 4'b0000, a3ff, zd, 4'b0100, 1, 4'b0000, 0);
    row(0, 4'b0000, 4'b0000, za, zd, 4'b0000, 0, 4'b0100, 32'h0000_1234);
    // read accepted, then reset lands on the response cycle
    row(0, 4'b0001, 4'b0000, a5, zd, 4'b0001, 1, 4'b0000, 0);
    row(1, 4'b0000, 4'b0000, za, zd, 4'b0000, 0, 4'b0000, 0);
    row(0, 4'b0000, 4'b0000, za, zd, 4'b0000, 0, 4'b0000, 0);
    row(0, 4'b0110, 4'b0000, a21, zd, 4'b0010, 1, 4'b0000, 0);
    row(0, 4'b0000, 4'b0000, za, zd, 4'b0000, 0, 4'b0010, init_word(10'h21));

    foreach (vecs[r]) begin
      int gi;
      logic [AW+DW:0] exp_mux;
      @(posedge clk);
      #1;
      rst = vecs[r].rst; req_valid = vecs[r].valid; req_we = vecs[r].we;
      req_addr = vecs[r].addr; req_wdata = vecs[r].wdata;
      @(negedge clk);
      chk("req_ready", r, 64'(req_ready), 64'(vecs[r].exp_ready));
      chk("ram_en", r, 64'(ram_en), 64'(vecs[r].exp_en));
      chk("rsp_valid", r, 64'(rsp_valid), 64'(vecs[r].exp_rsp));
      if (vecs[r].exp_rsp != '0) chk("rsp_rdata", r, 64'(rsp_rdata), 64'(vecs[r].exp_rdata));
      gi = -1;
      for (int i = 0; i < N; i++) if (vecs[r].exp_ready[i]) gi = i;
      exp_mux = '0;
      if (gi >= 0) exp_mux = {vecs[r].we[gi], vecs[r].addr[gi], vecs[r].wdata[gi]};
      chk("ram_mux", r, 64'({ram_we, ram_addr, ram_din}), 64'(exp_mux));
    end

`ifdef IOB_RAM_TDP_ARB_LOCK_EN
    // pointer is 2 here; one req0 grant moves it to 1, then req1 locks for three cycles
    drive(4'b0001, 4'b0000, 4'b0001, 100);
    drive(4'b1011, 4'b0010, 4'b0010, 101);
    drive(4'b1011, 4'b0010, 4'b0010, 102);
    drive(4'b1011, 4'b0010, 4'b0010, 103);
    drive(4'b1001, 4'b0000, 4'b1000, 104);
    drive(4'b1001, 4'b0000, 4'b0001, 105);
`endif

    @(posedge clk);
    #1;
    req_valid = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
